// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit/control bundle between the alarm top and the display scanner.
//   *_now      : current-time BCD digits (hour tens/ones, minute tens/ones)
//   *_bud      : alarm-time BCD digits
//   blink_en   : alarm ringing, blink the current-time digits
//   seg/dp/an  : active-low segment, decimal-point and anode drives
// master drives digits/blink_en and observes the display; slave is the scanner.
interface seg7_scan_if;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic [3:0] hourdec_bud;
  logic [3:0] hourone_bud;
  logic [3:0] mindec_bud;
  logic [3:0] minone_bud;
  logic       blink_en;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  modport master (
    output hourdec_now, hourone_now, mindec_now, minone_now,
    output hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    output blink_en,
    input  seg, dp, an
  );

  modport slave (
    input  hourdec_now, hourone_now, mindec_now, minone_now,
    input  hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    input  blink_en,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit common-anode 7-segment scanner.
//   Digits 0-3 show the current time, 4-7 the alarm time. Inputs are sampled
//   into shadow registers once per scan frame so the display never tears.
// Ports:
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : seg7_scan_if.slave (digits, blink_en in; seg/dp/an out, all registered)
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000,
  parameter int unsigned LZB         = 1
) (
  input  logic        clk,
  input  logic        rstn,
  seg7_scan_if.slave  bus
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0] r_ref_cnt;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;
  logic [3:0]    r_shadow [8];
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_blink_tc;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic          w_dark;
  logic [7:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  // BCD to active-low {G..A}; non-decimal values show a dash
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_ref_cnt == RW'(REFRESH_DIV - 1));
  assign w_blink_tc = (r_blink_cnt == BW'(BLINK_DIV - 1));

  // Refresh divider and digit index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else if (w_tick) begin
      r_ref_cnt <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + RW'(1);
    end
  end

  // Frame-boundary snapshot of all eight digits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else if (w_tick && (r_idx == 3'd7)) begin
      r_shadow[0] <= bus.minone_now;
      r_shadow[1] <= bus.mindec_now;
      r_shadow[2] <= bus.hourone_now;
      r_shadow[3] <= bus.hourdec_now;
      r_shadow[4] <= bus.minone_bud;
      r_shadow[5] <= bus.mindec_bud;
      r_shadow[6] <= bus.hourone_bud;
      r_shadow[7] <= bus.hourdec_bud;
    end
  end

  // Blink phase; parked in the on-phase while not ringing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (!bus.blink_en) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_blink_tc) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Next display drive. blink_en gates darkness directly so that dropping it
  // restores digits 0-3 on the very next registered update.
  always_comb begin
    w_digit = r_shadow[r_idx];
    w_blank = (LZB != 0) && (r_idx[1:0] == 2'd3) && (w_digit == 4'd0);
    w_dark  = bus.blink_en && !r_blink_on && !r_idx[2];
    w_an    = ~(8'd1 << r_idx);
    if (w_dark) w_an = 8'hFF;
    w_seg   = w_blank ? 7'h7F : f_decode(w_digit);
    w_dp    = !(r_idx[1:0] == 2'd2);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage of the alarm top. Consumes the BCD time digits from the watch (hourdec/hourone/mindec/minone "now") and the alarm-set digits ("bud").
- Time-multiplexes them onto an 8-digit common-anode 7-segment display: digits 0-3 show the current time, digits 4-7 show the alarm time.
- Provides leading-zero blanking, invalid-digit indication, and blinking of the current-time digits while the alarm rings.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays active (1 kHz per digit at 100 MHz); legal range >=2.
- BLINK_DIV, 50000000, clk cycles per blink half-period; legal range >=2.
- LZB, 1, 1 = blank hour-tens digit (idx 3 and 7) when its value is 0.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  current-time BCD digits
- hourdec_bud, hourone_bud, mindec_bud, minone_bud  in  4 each  alarm-time BCD digits
- blink_en  in  1  alarm ringing; blink current-time digits
- seg  out  7  segments, active-low; seg[0]=CA ... seg[6]=CG
- dp  out  1  decimal point, active-low
- an  out  8  digit anodes, active-low; an[i]=0 selects digit i

Behaviour:
- Reset (rstn=0, async):
  - an=8'hFF, seg=7'h7F, dp=1.
  - refresh counter=0, idx=0, blink counter=0, blink phase=on.
  - All 8 shadow digit registers=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick=1 in the cycle where count==REFRESH_DIV-1.
  - On tick, idx increments mod 8 (3-bit wrap 7->0).
- Shadow load (anti-tearing):
  - On a tick with idx==7, all 8 input digits are sampled into the shadow registers in that cycle.
  - Inputs are otherwise ignored. Display content changes only at scan-frame boundaries.
- Digit map (idx -> shadow):
  - 0 minone_now, 1 mindec_now, 2 hourone_now, 3 hourdec_now.
  - 4 minone_bud, 5 mindec_bud, 6 hourone_bud, 7 hourdec_bud.
- Decode, active-low {G..A}:
  - 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 display '-' (7'b0111111).
- dp=0 only when idx is 2 or 6 (hour/minute separator); otherwise 1.
- Leading-zero blanking: if LZB=1, idx is 3 or 7, and the shadow value is 0, then seg=7'h7F and dp=1. The anode is still driven.
- Blink:
  - While blink_en=0, the blink counter and phase are held at reset values (phase=on).
  - While blink_en=1, the counter counts 0..BLINK_DIV-1, toggles phase at terminal count, and wraps.
  - The first on-phase after assertion therefore lasts exactly BLINK_DIV cycles.
  - In the off-phase, an bits 0-3 are forced to 1 (digits 0-3 dark). Digits 4-7 are unaffected.
- Output registration:
  - an/seg/dp are registered from the current idx and shadow registers, so there is 1 clk of latency after an idx change.
  - Exactly one an bit is 0 at any time, except during reset or a blink off-phase on idx 0-3, when all bits are 1.
- Deassertion of blink_en mid off-phase: digits 0-3 reappear on the next registered update (1 cycle).
- Reset mid-scan: all state returns immediately to reset values. Scanning restarts at idx 0 after rstn release.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset and blank: REFRESH_DIV=4, BLINK_DIV=32, LZB=1; hold rstn=0 -> an=FF, seg=7F, dp=1. Release rstn -> an=FE (idx 0, shadow 0) with seg=7'b1000000 on the cycle after release.
- Frame latch: drive now=1,2,3,4 (hourdec..minone) and bud=0,7,3,0. After the first idx-7 tick, check the next frame:
  - an=FE shows seg=0011001 ('4').
  - an=FB shows '2' with dp=0.
  - an=F7 shows '1'.
  - an=7F shows seg=7F (LZB blanking).
  - Changing inputs mid-frame must not alter the current frame.
- Scan order and timing: each an pattern FE,FD,FB,F7,EF,DF,BF,7F holds exactly 4 cycles, then wraps to FE.
- Invalid BCD: minone_now=4'hC -> idx 0 shows seg=0111111. With LZB=0, hourdec_bud=0 shows '0' on an=7F.
- Blink:
  - Assert blink_en: digits 0-3 stay visible for 32 cycles.
  - For the next 32 cycles, an[3:0] stays 4'hF while an[7:4] continues scanning.
  - Deassert blink_en mid off-phase -> digits 0-3 visible again within 1 cycle.
- Async reset mid-operation: pulse rstn low for 3 cycles at idx 5 during a blink off-phase -> outputs go to reset values in the same cycle, and scanning resumes from idx 0 with shadows cleared.
